// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (also used by the receiver) and framing constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 868;
   localparam int DATA_BITS            = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      ,
      ST_PARITY = 3'd4
`endif
   } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: bit_done is high on the last cycle of each bit; restart or bit_done reloads to zero.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic CLK,
   input  logic reset,
   input  logic restart,
   output logic bit_done
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (restart || bit_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   assign bit_done = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// Double-buffered UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// tx_out is registered from the current state, so the start bit falls two cycles after a load.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       ld_tx_data,
   input  logic [7:0] tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_overrun
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   uart_state_e          state, state_next;
   logic [DATA_BITS-1:0] hold_reg, shift_reg;
   logic [2:0]           bit_idx;
   logic                 bit_done, restart, take, line_bit, can_start;
`ifdef UART_TX_PARITY_EN
   logic                 parity_bit;
`endif

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .CLK      (CLK),
      .reset    (reset),
      .restart  (restart),
      .bit_done (bit_done)
   );

   assign can_start = tx_enable && !tx_empty;
   assign tx_busy   = (state != ST_IDLE);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (can_start) state_next = ST_START;
         ST_START: if (bit_done) state_next = ST_DATA;
         ST_DATA:  if (bit_done && bit_idx == LAST_BIT)
`ifdef UART_TX_PARITY_EN
                      state_next = ST_PARITY;
         ST_PARITY: if (bit_done) state_next = ST_STOP;
`else
                      state_next = ST_STOP;
`endif
         ST_STOP:  if (bit_done) state_next = can_start ? ST_START : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      restart  = 1'b0;
      take     = 1'b0;
      line_bit = 1'b1;
      case (state)
         ST_IDLE: begin
            restart = 1'b1;
            take    = can_start;
         end
         ST_START:  line_bit = 1'b0;
         ST_DATA:   line_bit = shift_reg[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: line_bit = parity_bit;
`endif
         ST_STOP:   take = bit_done && can_start;
         default:   line_bit = 1'b1;
      endcase
   end

   // A load and a holding-to-shift transfer never share an edge: one needs tx_empty=1, the other tx_empty=0.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         hold_reg   <= '0;
         shift_reg  <= '0;
         bit_idx    <= '0;
         tx_empty   <= 1'b1;
         tx_overrun <= 1'b0;
         tx_out     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_out <= line_bit;
         if (ld_tx_data) begin
            if (tx_empty) begin
               hold_reg <= tx_data;
               tx_empty <= 1'b0;
            end else begin
               tx_overrun <= 1'b1;
            end
         end
         if (take) begin
            shift_reg <= hold_reg;
            bit_idx   <= '0;
            tx_empty  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^hold_reg;
`endif
         end else if (state == ST_DATA && bit_done) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLKS_PER_BIT=4): directed scenarios plus random traffic,
// compared every cycle against a frame-timing reference model. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       ld_tx_data = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_enable = 1'b0;
   logic       tx_out, tx_empty, tx_busy, tx_overrun;

   int errors = 0;
   int checks = 0;

   // Reference model: a frame is a bit vector, the line value is frame[elapsed / CPB].
   logic          m_full, m_active, m_over, m_line;
   logic [7:0]    m_hold;
   logic [FB-1:0] m_bits;
   int            m_pos;

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .ld_tx_data (ld_tx_data),
      .tx_data    (tx_data),
      .tx_enable  (tx_enable),
      .tx_out     (tx_out),
      .tx_empty   (tx_empty),
      .tx_busy    (tx_busy),
      .tx_overrun (tx_overrun)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [FB-1:0] build_frame(input logic [7:0] d);
      logic [FB-1:0] f;
      f        = '1;
      f[0]     = 1'b0;
      f[8:1]   = d;
`ifdef UART_TX_PARITY_EN
      f[9]     = ^d;
`endif
      return f;
   endfunction

   // Advance the model across one rising edge given the inputs present before it.
   task automatic model_step(input logic ld, input logic [7:0] d, input logic en);
      logic full_pre, last, take, line_next;
      if (!reset) begin
         m_full = 1'b0; m_active = 1'b0; m_over = 1'b0; m_line = 1'b1;
         m_hold = 8'h00; m_bits = '1; m_pos = 0;
         return;
      end
      full_pre  = m_full;
      line_next = m_active ? m_bits[m_pos / CPB] : 1'b1;
      last      = m_active && (m_pos == FB * CPB - 1);
      take      = full_pre && en && (!m_active || last);
      if (m_active) begin
         if (last) m_active = 1'b0;
         else      m_pos++;
      end
      if (take) begin
         m_active = 1'b1;
         m_pos    = 0;
         m_bits   = build_frame(m_hold);
         m_full   = 1'b0;
      end
      if (ld) begin
         if (!full_pre) begin
            m_hold = d;
            m_full = 1'b1;
         end else begin
            m_over = 1'b1;
         end
      end
      m_line = line_next;
   endtask

   // Drive inputs at the falling edge, step the model, and compare at the next falling edge.
   task automatic cycle(input logic ld, input logic [7:0] d, input logic en);
      ld_tx_data = ld;
      tx_data    = d;
      tx_enable  = en;
      model_step(ld, d, en);
      @(posedge CLK);
      @(negedge CLK);
      check("tx_out", tx_out, m_line);
      check("tx_empty", tx_empty, !m_full);
      check("tx_busy", tx_busy, m_active);
      check("tx_overrun", tx_overrun, m_over);
      ld_tx_data = 1'b0;
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), en);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle(3, 1'b0);
      reset = 1'b1;
   endtask

   initial begin
      logic en;
      @(negedge CLK);
      idle(3, 1'b0);
      check("rst_tx_out", tx_out, 1'b1);
      check("rst_tx_empty", tx_empty, 1'b1);
      check("rst_tx_busy", tx_busy, 1'b0);
      check("rst_tx_overrun", tx_overrun, 1'b0);
      reset = 1'b1;

      // 0x55 from idle: line still high one edge after the load, low on the second.
      cycle(1'b1, 8'h55, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check("latency_high", tx_out, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      check("latency_low", tx_out, 1'b0);
      idle(FB * CPB + 2, 1'b1);
      check("frame_done_busy", tx_busy, 1'b0);

      // Second byte loaded mid-frame runs back-to-back.
      cycle(1'b1, 8'hA5, 1'b1);
      idle(15, 1'b1);
      cycle(1'b1, 8'h3C, 1'b1);
      idle(2 * FB * CPB + 10, 1'b1);
      check("b2b_overrun", tx_overrun, 1'b0);

      // With transfers blocked, 0x11 fills the holding register so the later loads overflow.
      cycle(1'b1, 8'h11, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      cycle(1'b1, 8'h33, 1'b0);
      check("overrun_set", tx_overrun, 1'b1);
      idle(FB * CPB + 10, 1'b1);
      check("overrun_sticky", tx_overrun, 1'b1);
      do_reset();

      // Disable during bit 3 of 0xF0 with 0x0F pending.
      cycle(1'b1, 8'hF0, 1'b1);
      idle(3, 1'b1);
      cycle(1'b1, 8'h0F, 1'b1);
      idle(10, 1'b1);
      idle(FB * CPB + 10, 1'b0);
      check("hold_line_high", tx_out, 1'b1);
      check("hold_pending", tx_empty, 1'b0);
      idle(FB * CPB + 5, 1'b1);
      check("pending_sent", tx_empty, 1'b1);

      // Asynchronous reset during bit 5 of a frame with a second byte queued.
      cycle(1'b1, 8'hC3, 1'b1);
      idle(3, 1'b1);
      cycle(1'b1, 8'h99, 1'b1);
      idle(2 + 5 * CPB - 4, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("async_tx_out", tx_out, 1'b1);
      check("async_tx_empty", tx_empty, 1'b1);
      check("async_tx_busy", tx_busy, 1'b0);
      idle(2, 1'b1);
      reset = 1'b1;
      idle(FB * CPB + 5, 1'b1);
      check("no_frame_after_rst", tx_busy, 1'b0);

`ifdef UART_TX_PARITY_EN
      // Parity bit (frame bit 9) is valid from edge 2+9*CPB after the load.
      cycle(1'b1, 8'h07, 1'b1);
      idle(2 + 9 * CPB + 1, 1'b1);
      check("parity_07", tx_out, 1'b1);
      idle(CPB + 5, 1'b1);
      cycle(1'b1, 8'h03, 1'b1);
      idle(2 + 9 * CPB + 1, 1'b1);
      check("parity_03", tx_out, 1'b0);
      idle(CPB + 5, 1'b1);
`endif

      // Random traffic: sparse loads, occasional enable toggling, loads often collide with a full buffer.
      en = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 149) == 0) en = !en;
         cycle($urandom_range(0, 19) == 0, 8'($urandom), en);
      end
      idle(FB * CPB * 2 + 5, 1'b1);
      check("drain_busy", tx_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
